// File: rtl/flash_bus_arbiter_pkg.sv
// Shared constants for the flash bus arbiter: FSM state codes, owner
// encoding and default timing parameters.
package flash_bus_arbiter_pkg;

  localparam int DEF_WAIT_CYCLES  = 3;
  localparam int DEF_STARVE_LIMIT = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_RECOV = 3'd4;

  typedef enum logic {
    OWN_GB  = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/flash_arb_prio.sv
// Two-requester fixed priority (cartridge first) with a starvation counter
// that forces a debugger grant after STARVE_LIMIT cartridge wins.
module flash_arb_prio
  import flash_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   arb_en,
  input  logic   gb_req,
  input  logic   dbg_req,
  output logic   grant,
  output owner_e owner
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    grant = gb_req | dbg_req;
    owner = (dbg_req && (!gb_req || starved)) ? OWN_DBG : OWN_GB;
  end

  // Only cartridge wins with the debugger waiting count toward starvation.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en && grant) begin
      if (owner == OWN_DBG)
        starve_cnt <= '0;
      else if (dbg_req && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Shares the 16-bit async flash bus between cartridge byte reads and
// debugger word reads, generating CE/OE/ADV timing on the memory clock.
module flash_bus_arbiter
  import flash_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 23,
  parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gb_req,
  input  logic [ADDR_W-1:0] gb_addr,
  output logic [7:0]        gb_rdata,
  output logic              gb_ack,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [15:0]       dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-2:0] flash_a,
  input  logic [15:0]       flash_d,
  output logic              flash_ce_b,
  output logic              flash_oe_b,
  output logic              flash_adv_b,
  output logic              flash_we_b,
  output logic              busy
);

  logic [2:0] state;
  logic [3:0] wait_cnt;
  owner_e     owner;
  logic       lane;
  logic       arb_grant;
  owner_e     arb_owner;
  logic       unused_dbg_lsb;

  // Debugger reads are always whole words.
  assign unused_dbg_lsb = dbg_addr[0];

  flash_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state == ST_IDLE),
    .gb_req (gb_req),
    .dbg_req(dbg_req),
    .grant  (arb_grant),
    .owner  (arb_owner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_GB;
      lane      <= 1'b0;
      flash_a   <= '0;
      wait_cnt  <= '0;
      gb_rdata  <= '0;
      dbg_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_grant) begin
            owner <= arb_owner;
            if (arb_owner == OWN_DBG) begin
              flash_a <= dbg_addr[ADDR_W-1:1];
              lane    <= 1'b0;
            end else begin
              flash_a <= gb_addr[ADDR_W-1:1];
              lane    <= gb_addr[0];
            end
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          wait_cnt <= 4'(WAIT_CYCLES - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            if (owner == OWN_DBG)
              dbg_rdata <= flash_d;
            else
              gb_rdata <= lane ? flash_d[15:8] : flash_d[7:0];
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DONE:  state <= ST_RECOV;
        ST_RECOV: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    flash_ce_b  = !((state == ST_ADDR) || (state == ST_WAIT));
    flash_adv_b = (state != ST_ADDR);
    flash_oe_b  = (state != ST_WAIT);
    flash_we_b  = 1'b1;
    busy        = (state != ST_IDLE);
    gb_ack      = (state == ST_DONE) && (owner == OWN_GB);
    dbg_ack     = (state == ST_DONE) && (owner == OWN_DBG);
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: default build plus a WAIT_CYCLES=1 build.
module tb_flash_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        gb_req, dbg_req;
  logic [22:0] gb_addr, dbg_addr;
  logic [7:0]  gb_rdata;
  logic [15:0] dbg_rdata, flash_d;
  logic        gb_ack, dbg_ack;
  logic [21:0] flash_a;
  logic        ce_b, oe_b, adv_b, we_b, busy;

  logic        w1_gb_req, w1_dbg_req;
  logic [22:0] w1_gb_addr, w1_dbg_addr;
  logic [7:0]  w1_gb_rdata;
  logic [15:0] w1_dbg_rdata, w1_flash_d;
  logic        w1_gb_ack, w1_dbg_ack;
  logic [21:0] w1_flash_a;
  logic        w1_ce_b, w1_oe_b, w1_adv_b, w1_we_b, w1_busy;

  int n_vec = 0;
  int n_err = 0;
  int oe_cnt;

  always #5 clk = ~clk;

  flash_bus_arbiter u_dut (
    .clk(clk), .rst(rst),
    .gb_req(gb_req), .gb_addr(gb_addr), .gb_rdata(gb_rdata), .gb_ack(gb_ack),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .flash_a(flash_a), .flash_d(flash_d), .flash_ce_b(ce_b), .flash_oe_b(oe_b),
    .flash_adv_b(adv_b), .flash_we_b(we_b), .busy(busy)
  );

  flash_bus_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst),
    .gb_req(w1_gb_req), .gb_addr(w1_gb_addr), .gb_rdata(w1_gb_rdata), .gb_ack(w1_gb_ack),
    .dbg_req(w1_dbg_req), .dbg_addr(w1_dbg_addr), .dbg_rdata(w1_dbg_rdata), .dbg_ack(w1_dbg_ack),
    .flash_a(w1_flash_a), .flash_d(w1_flash_d), .flash_ce_b(w1_ce_b), .flash_oe_b(w1_oe_b),
    .flash_adv_b(w1_adv_b), .flash_we_b(w1_we_b), .busy(w1_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    gb_req = 0; dbg_req = 0; gb_addr = '0; dbg_addr = '0; flash_d = '0;
    w1_gb_req = 0; w1_dbg_req = 0; w1_gb_addr = '0; w1_dbg_addr = '0; w1_flash_d = '0;
    step(); step();

    // reset state
    chk("rst_ce", ce_b, 1);   chk("rst_oe", oe_b, 1);   chk("rst_adv", adv_b, 1);
    chk("rst_we", we_b, 1);   chk("rst_a", flash_a, 0); chk("rst_gbd", gb_rdata, 0);
    chk("rst_dbgd", dbg_rdata, 0); chk("rst_gback", gb_ack, 0);
    chk("rst_dbgack", dbg_ack, 0); chk("rst_busy", busy, 0);
    chk("rst_w1_ce", w1_ce_b, 1);
    rst = 1'b0;
    step();

    // single cartridge read, high lane
    gb_addr = 23'h00003; flash_d = 16'hA55A; gb_req = 1;
    step();
    chk("gb_a", flash_a, 22'h000001); chk("gb_adv1", adv_b, 0);
    chk("gb_ce1", ce_b, 0); chk("gb_oe1", oe_b, 1); chk("gb_busy1", busy, 1);
    for (int t = 2; t <= 4; t++) begin
      step();
      chk("gb_oe_wait", oe_b, 0); chk("gb_adv_wait", adv_b, 1); chk("gb_ack_wait", gb_ack, 0);
    end
    step();
    chk("gb_ack5", gb_ack, 1); chk("gb_data", gb_rdata, 8'hA5);
    chk("gb_dbgack5", dbg_ack, 0); chk("gb_oe5", oe_b, 1);
    gb_req = 0;
    step();
    chk("gb_ack6", gb_ack, 0); chk("gb_ce6", ce_b, 1); chk("gb_busy6", busy, 1);
    step();
    chk("gb_idle", busy, 0);

    // single debugger read
    dbg_addr = 23'h12344; flash_d = 16'hBEEF; dbg_req = 1;
    step();
    chk("dbg_a", flash_a, 22'h0091A2);
    for (int t = 2; t <= 4; t++) begin
      step();
      chk("dbg_ack_wait", dbg_ack, 0);
    end
    step();
    chk("dbg_ack5", dbg_ack, 1); chk("dbg_data", dbg_rdata, 16'hBEEF);
    chk("dbg_gbdata", gb_rdata, 8'hA5); chk("dbg_gback5", gb_ack, 0);
    dbg_req = 0;
    step(); step();

    // simultaneous single requests: gb first, dbg one period later
    gb_addr = 23'h00010; dbg_addr = 23'h00020; flash_d = 16'h1234;
    gb_req = 1; dbg_req = 1;
    for (int t = 1; t <= 12; t++) begin
      step();
      chk("sim_gback", gb_ack, (t == 5));
      chk("sim_dbgack", dbg_ack, (t == 12));
      if (t == 5) begin
        chk("sim_gbdata", gb_rdata, 8'h34);
        gb_req = 0; flash_d = 16'h5678;
      end
      if (t == 8) chk("sim_dbga", flash_a, 22'h000010);
      if (t == 12) begin
        chk("sim_dbgdata", dbg_rdata, 16'h5678);
        dbg_req = 0;
      end
    end
    step(); step();

    // both held: gb x4 then dbg, acks every 7 cycles
    gb_addr = 23'h00001; dbg_addr = 23'h00100; flash_d = 16'h0F0F;
    gb_req = 1; dbg_req = 1;
    for (int t = 1; t <= 35; t++) begin
      step();
      chk("cont_gback", gb_ack, ((t % 7) == 5) && ((t / 7) != 4));
      chk("cont_dbgack", dbg_ack, ((t % 7) == 5) && ((t / 7) == 4));
      chk("cont_both", gb_ack & dbg_ack, 0);
    end
    gb_req = 0; dbg_req = 0;
    step();
    chk("cont_idle", busy, 0);

    // reset during WAIT discards the access
    gb_addr = 23'h00005; flash_d = 16'hCAFE; gb_req = 1;
    step(); step();
    chk("rw_in_wait", oe_b, 0);
    rst = 1;
    step();
    chk("rw_ce", ce_b, 1); chk("rw_oe", oe_b, 1); chk("rw_adv", adv_b, 1);
    chk("rw_busy", busy, 0); chk("rw_ack", gb_ack, 0); chk("rw_gbd", gb_rdata, 0);
    rst = 0;
    for (int t = 1; t <= 5; t++) begin
      step();
      chk("rw_restart_ack", gb_ack, (t == 5));
    end
    chk("rw_data", gb_rdata, 8'hCA);
    gb_req = 0;
    step(); step();

    // WAIT_CYCLES=1 build
    w1_gb_addr = 23'h00002; w1_flash_d = 16'h3C5A; w1_gb_req = 1;
    oe_cnt = 0;
    for (int t = 1; t <= 4; t++) begin
      step();
      if (!w1_oe_b) oe_cnt++;
      chk("w1_ack", w1_gb_ack, (t == 3));
      if (t == 3) begin
        chk("w1_data", w1_gb_rdata, 8'h5A);
        w1_gb_req = 0;
      end
    end
    chk("w1_oe_cycles", oe_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
